// File: rtl/fixed_sm_converter.sv
// Converts words between sign-magnitude and two's complement, in either direction.
// Each accepted word is converted and then held in a 2-entry output FIFO.
module fixed_sm_converter #(
  parameter int NUMWIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUMWIDTH:0]   in_data,
  input  logic                in_dir,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUMWIDTH:0]   out_data,
  output logic                out_sat,
  input  logic                clear_count,
  output logic [15:0]         sat_count
);

  localparam int W = NUMWIDTH + 1;
  localparam logic [W-1:0] ONE = {{NUMWIDTH{1'b0}}, 1'b1};

  // Returns {sat, word}. The single value -2^NUMWIDTH has no sign-magnitude form.
  function automatic logic [W:0] convert(input logic [W-1:0] d, input logic dir);
    logic [W:0]   r;
    logic [W-1:0] neg;
    r   = {(W+1){1'b0}};
    neg = ~d + ONE;
    if (!dir) begin
      if (!d[NUMWIDTH]) begin
        r = {1'b0, d};
      end else if (d[NUMWIDTH-1:0] == {NUMWIDTH{1'b0}}) begin
        r = {(W+1){1'b0}};
      end else begin
        r = {1'b0, ~{1'b0, d[NUMWIDTH-1:0]} + ONE};
      end
    end else begin
      if (!d[NUMWIDTH]) begin
        r = {1'b0, d};
      end else if (d[NUMWIDTH-1:0] == {NUMWIDTH{1'b0}}) begin
        r = {1'b1, 1'b1, {NUMWIDTH{1'b1}}};
      end else begin
        r = {1'b0, 1'b1, neg[NUMWIDTH-1:0]};
      end
    end
    return r;
  endfunction

  logic [1:0]   count_r;
  logic [W-1:0] head_data_r, tail_data_r;
  logic         head_sat_r, tail_sat_r;
  logic         out_valid_r, in_ready_r;
  logic [15:0]  sat_count_r;

  logic         push_s, pop_s;
  logic [W:0]   conv_s;
  logic [1:0]   count_next_s;

  // Handshakes, conversion of the offered word and next FIFO occupancy.
  always_comb begin
    push_s       = in_valid && in_ready_r;
    pop_s        = out_valid_r && out_ready;
    conv_s       = convert(in_data, in_dir);
    count_next_s = count_r;
    case (count_r)
      2'd0:    count_next_s = push_s ? 2'd1 : 2'd0;
      2'd1: begin
        if (push_s && !pop_s) begin
          count_next_s = 2'd2;
        end else if (!push_s && pop_s) begin
          count_next_s = 2'd0;
        end else begin
          count_next_s = 2'd1;
        end
      end
      2'd2:    count_next_s = pop_s ? 2'd1 : 2'd2;
      default: count_next_s = 2'd0;
    endcase
  end

  // FIFO storage, registered handshake flags and saturation counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r     <= 2'd0;
      head_data_r <= {W{1'b0}};
      head_sat_r  <= 1'b0;
      tail_data_r <= {W{1'b0}};
      tail_sat_r  <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      sat_count_r <= 16'h0000;
    end else begin
      count_r     <= count_next_s;
      out_valid_r <= (count_next_s != 2'd0);
      in_ready_r  <= (count_next_s != 2'd2);
      case (count_r)
        2'd0: begin
          if (push_s) begin
            head_data_r <= conv_s[W-1:0];
            head_sat_r  <= conv_s[W];
          end
        end
        2'd1: begin
          // With a simultaneous pop the new word goes straight to the head.
          if (push_s && pop_s) begin
            head_data_r <= conv_s[W-1:0];
            head_sat_r  <= conv_s[W];
          end else if (push_s) begin
            tail_data_r <= conv_s[W-1:0];
            tail_sat_r  <= conv_s[W];
          end
        end
        2'd2: begin
          if (pop_s) begin
            head_data_r <= tail_data_r;
            head_sat_r  <= tail_sat_r;
          end
        end
        default: begin
          head_data_r <= {W{1'b0}};
          head_sat_r  <= 1'b0;
        end
      endcase
      if (clear_count) begin
        sat_count_r <= 16'h0000;
      end else if (push_s && conv_s[W] && (sat_count_r != 16'hFFFF)) begin
        sat_count_r <= sat_count_r + 16'h0001;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = head_data_r;
  assign out_sat   = head_sat_r;
  assign sat_count = sat_count_r;

endmodule

// File: tb/tb_fixed_sm_converter.sv
// Bench for fixed_sm_converter: directed vectors plus randomized traffic.
// Expected values come from an integer-arithmetic reference model and a queue.
module tb_fixed_sm_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] in_data = 17'h00000;
  logic        in_dir = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [16:0] out_data;
  logic        out_sat;
  logic        clear_count = 1'b0;
  logic [15:0] sat_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];
  int exp_cnt = 0;

  fixed_sm_converter #(.NUMWIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dir(in_dir), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .clear_count(clear_count), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  // Reference: interpret the word as an integer, then re-encode it.
  function automatic logic [17:0] ref_conv(input logic [16:0] d, input logic dir);
    int v;
    int mag;
    if (!dir) begin
      v = d[16] ? -int'(d[15:0]) : int'(d[15:0]);
      return {1'b0, 17'(v)};
    end
    v = d[16] ? int'(d) - 131072 : int'(d);
    if (v == -65536) return {1'b1, 1'b1, 16'hFFFF};
    mag = (v < 0) ? -v : v;
    return {1'b0, (v < 0), 16'(mag)};
  endfunction

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic tick();
    logic [17:0] c;
    bit push, pop;
    c    = ref_conv(in_data, in_dir);
    push = in_valid && (exp_q.size() != 2);
    pop  = (exp_q.size() != 0) && out_ready;
    @(posedge clk); #1;
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back(c);
      if (clear_count) exp_cnt = 0;
      else if (push && c[17] && exp_cnt < 65535) exp_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 17'h10000; in_dir = 1'b1;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 17'h0) begin n_err++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_cmp++; if (out_sat !== 1'b0) begin n_err++; $display("FAIL reset_out_sat got %b want 0", out_sat); end
    n_cmp++; if (sat_count !== 16'h0) begin n_err++; $display("FAIL reset_sat_count got %h want 0", sat_count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    in_valid = 1'b0; rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sm2c();
    logic [16:0] vin[4]  = '{17'h00005, 17'h10005, 17'h10000, 17'h1FFFF};
    logic [16:0] vout[4] = '{17'h00005, 17'h1FFFB, 17'h00000, 17'h10001};
    out_ready = 1'b1; in_valid = 1'b1; in_dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = vin[i];
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== vout[i] || out_sat !== 1'b0) begin
        n_err++; $display("FAIL sm2c_%0d got v=%b d=%h s=%b want v=1 d=%h s=0", i, out_valid, out_data, out_sat, vout[i]);
      end
    end
    in_valid = 1'b0; tick();
  endtask

  task automatic test_2c2sm();
    logic [16:0] vin[3]  = '{17'h1FFFB, 17'h0FFFF, 17'h10000};
    logic [16:0] vout[3] = '{17'h10005, 17'h0FFFF, 17'h1FFFF};
    logic        vsat[3] = '{1'b0, 1'b0, 1'b1};
    out_ready = 1'b1; in_valid = 1'b1; in_dir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = vin[i];
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== vout[i] || out_sat !== vsat[i]) begin
        n_err++; $display("FAIL 2c2sm_%0d got v=%b d=%h s=%b want v=1 d=%h s=%b", i, out_valid, out_data, out_sat, vout[i], vsat[i]);
      end
    end
    n_cmp++; if (sat_count !== 16'd1) begin n_err++; $display("FAIL 2c2sm_sat_count got %0d want 1", sat_count); end
    in_valid = 1'b0; tick();
  endtask

  task automatic test_backpressure();
    logic [16:0] a, b, c;
    a = 17'($urandom); b = 17'($urandom); c = 17'($urandom);
    out_ready = 1'b0; in_valid = 1'b1; in_dir = 1'b0;
    in_data = a; tick();
    in_data = b; tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_in_ready got %b want 0", in_ready); end
    in_data = c;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== ref_conv(a, 1'b0)) begin
        n_err++; $display("FAIL bp_hold_%0d got r=%b d=%h want r=0 d=%h", i, in_ready, out_data, ref_conv(a, 1'b0));
      end
    end
    out_ready = 1'b1; tick();
    n_cmp++; if (in_ready !== 1'b1 || out_data !== ref_conv(b, 1'b0)) begin
      n_err++; $display("FAIL bp_pop got r=%b d=%h want r=1 d=%h", in_ready, out_data, ref_conv(b, 1'b0));
    end
    out_ready = 1'b0; tick();
    n_cmp++; if (in_ready !== 1'b0 || out_data !== ref_conv(b, 1'b0)) begin
      n_err++; $display("FAIL bp_third_accept got r=%b d=%h want r=0 d=%h", in_ready, out_data, ref_conv(b, 1'b0));
    end
    in_valid = 1'b0; out_ready = 1'b1; tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== ref_conv(c, 1'b0)) begin
      n_err++; $display("FAIL bp_order got v=%b d=%h want v=1 d=%h", out_valid, out_data, ref_conv(c, 1'b0));
    end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained got v=%b want 0", out_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      in_dir      = 1'($urandom);
      in_data     = ($urandom_range(0, 5) == 0) ? 17'h10000 : 17'($urandom);
      clear_count = ($urandom_range(0, 30) == 0);
      tick();
      n_cmp++; if (in_ready !== (exp_q.size() != 2) || out_valid !== (exp_q.size() != 0)) begin
        n_err++; $display("FAIL rand_flags_%0d got r=%b v=%b want size=%0d", i, in_ready, out_valid, exp_q.size());
      end
      if (exp_q.size() != 0) begin
        n_cmp++; if ({out_sat, out_data} !== exp_q[0]) begin
          n_err++; $display("FAIL rand_data_%0d got %h want %h", i, {out_sat, out_data}, exp_q[0]);
        end
      end
      n_cmp++; if (sat_count !== 16'(exp_cnt)) begin
        n_err++; $display("FAIL rand_cnt_%0d got %0d want %0d", i, sat_count, exp_cnt);
      end
    end
    in_valid = 1'b0; clear_count = 1'b0; out_ready = 1'b1;
    tick(); tick();
  endtask

  task automatic test_counter();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_dir = 1'b1; in_data = 17'h10000;
    tick(); tick(); tick();
    n_cmp++; if (sat_count !== 16'd3) begin n_err++; $display("FAIL cnt_three got %0d want 3", sat_count); end
    clear_count = 1'b1; tick(); clear_count = 1'b0;
    n_cmp++; if (sat_count !== 16'd0) begin n_err++; $display("FAIL cnt_clear_priority got %0d want 0", sat_count); end
    for (int i = 0; i < 65535; i++) tick();
    n_cmp++; if (sat_count !== 16'hFFFF) begin n_err++; $display("FAIL cnt_reach_max got %h want FFFF", sat_count); end
    tick(); tick(); tick();
    n_cmp++; if (sat_count !== 16'hFFFF) begin n_err++; $display("FAIL cnt_stick got %h want FFFF", sat_count); end
    in_valid = 1'b0; tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_dir = 1'b1; in_data = 17'h10000;
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b0 || sat_count !== 16'hFFFF) begin
      n_err++; $display("FAIL mid_prefill got r=%b cnt=%h want r=0 cnt=FFFF", in_ready, sat_count);
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || sat_count !== 16'h0) begin
      n_err++; $display("FAIL mid_reset got v=%b r=%b cnt=%h want v=0 r=1 cnt=0", out_valid, in_ready, sat_count);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_ghost_%0d got v=%b want 0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_sm2c();
    test_2c2sm();
    test_backpressure();
    test_random();
    test_counter();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
